sample_playback_ctrl: RTL and testbench

Output-side counterpart of the input decimator: accepts 13-bit signed samples from upstream logic via a valid/ready handshake and releases them to the DAC path at a fixed period (5000 clk = 50 µs at 100 MHz).
A small FIFO absorbs upstream burstiness.
Output pacing is set by a free-running period counter, not by data arrival.
Underruns are flagged and never corrupt the DAC output.

---
 rtl/sample_playback_ctrl_pkg.sv | 23 ++
 rtl/sample_fifo.sv | 59 +++++
 rtl/sample_playback_ctrl.sv | 91 +++++++++
 tb/tb_sample_playback_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_playback_ctrl_pkg.sv
// sample_playback_ctrl_pkg: shared widths, defaults, FSM encoding and width helper
package sample_playback_ctrl_pkg;

    localparam int DEF_DATA_W    = 13;
    localparam int DEF_PERIOD    = 5000;
    localparam int DEF_CNT_W     = 19;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_PRIME_LVL = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with flush; flush beats push and pop
module sample_fifo
    import sample_playback_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full    = level_q == LW'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign head    = mem_q[rd_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // next storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2**AW)
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = wr_data;
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        level_d = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    end

    // state registers; reset also clears stored samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sample_playback_ctrl.sv
// sample_playback_ctrl: paces queued samples to the DAC at a fixed period, flags underruns
module sample_playback_ctrl
    import sample_playback_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PRIME_LVL = DEF_PRIME_LVL,
    localparam int LW       = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_play,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_strobe,
    output logic              underrun,
    output logic [LW-1:0]     fifo_level
);

    logic              full, empty, push, pop, slot;
    logic [DATA_W-1:0] head;
    state_t            st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dac_q, dac_d;
    logic              strobe_q, strobe_d;
    logic              und_q, und_d;
    logic              en_q, en_d;

    // ready is purely FIFO space this cycle; a same-cycle pop never opens it
    assign in_ready   = !full && !flush;
    assign push       = in_valid && in_ready;
    assign slot       = st_q == ST_RUN && en_play && cnt_q == CNT_W'(PERIOD - 1);
    assign pop        = slot && !flush;
    assign dac_data   = dac_q;
    assign dac_strobe = strobe_q;
    assign underrun   = und_q;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level),
        .head    (head)
    );

    // playback FSM, period counter, output slot and sticky underrun
    always_comb begin
        st_d     = !en_play ? ST_IDLE
                 : st_q == ST_RUN ? ST_RUN
                 : (st_q == ST_PRIME && fifo_level >= LW'(PRIME_LVL)) ? ST_RUN
                 : ST_PRIME;
        cnt_d    = (st_q == ST_RUN && en_play && !slot) ? cnt_q + CNT_W'(1) : '0;
        strobe_d = slot;
        dac_d    = (slot && !empty && !flush) ? head : dac_q;
        und_d    = (en_q && !en_play) ? 1'b0 : und_q | (slot && (empty || flush));
        en_d     = en_play;
    end

    // controller registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            dac_q    <= '0;
            strobe_q <= 1'b0;
            und_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            dac_q    <= dac_d;
            strobe_q <= strobe_d;
            und_q    <= und_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: tb/tb_sample_playback_ctrl.sv
// tb_sample_playback_ctrl: queue-based reference model with a strobe-driven scoreboard
module tb_sample_playback_ctrl;

    localparam int P  = 8;
    localparam int D  = 4;
    localparam int PL = 2;
    localparam int W  = 13;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en_play = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, dac_strobe, underrun;
    logic [W-1:0] dac_data;
    logic [2:0]   fifo_level;

    sample_playback_ctrl #(.PERIOD(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_play    (en_play),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dac_data   (dac_data),
        .dac_strobe (dac_strobe),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] mq[$];
    logic [W:0]   sb[$];
    logic [W:0]   sb_e;
    int           mode = M_IDLE;
    int           phase = 0;
    logic [W-1:0] m_dac = '0;
    bit           m_und = 0;
    bit           m_strobe = 0;
    bit           en_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && dac_strobe) begin
            if (sb.size() == 0) chk("sb_unexpected_strobe", 1, 0);
            else begin
                sb_e = sb.pop_front();
                chk("sb_dac_data", dac_data, sb_e[W-1:0]);
                chk("sb_underrun", underrun, sb_e[W]);
            end
        end
    end

    task automatic step();
        bit rdy, slot, lvl_ok;
        #1;
        rdy    = (mq.size() < D) && !flush;
        slot   = (mode == M_RUN) && en_play && (phase == P - 1);
        lvl_ok = mq.size() >= PL;
        chk("in_ready", in_ready, rdy);
        if (flush) begin
            mq.delete();
            if (slot) m_und = 1;
        end else begin
            if (slot) begin
                if (mq.size() > 0) m_dac = mq.pop_front();
                else m_und = 1;
            end
            if (in_valid && rdy) mq.push_back(in_data);
        end
        if (en_prev && !en_play) m_und = 0;
        en_prev = en_play;
        if (!en_play) begin
            mode  = M_IDLE;
            phase = 0;
        end else if (mode == M_IDLE) mode = M_PRIME;
        else if (mode == M_PRIME) begin
            if (lvl_ok) begin
                mode  = M_RUN;
                phase = 0;
            end
        end else phase = (phase + 1) % P;
        m_strobe = slot;
        if (slot) sb.push_back({m_und, m_dac});
        @(posedge clk);
        #1;
        chk("dac_strobe", dac_strobe, m_strobe);
        chk("fifo_level", fifo_level, mq.size());
        chk("underrun", underrun, m_und);
        chk("dac_data", dac_data, m_dac);
    endtask

    task automatic run_to_phase(input int p);
        int n;
        n = 0;
        while (!(mode == M_RUN && phase == p) && n < 100) begin
            step();
            n++;
        end
        chk("reach_phase_in_budget", n < 100, 1);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_dac_data", dac_data, 0);
        chk("rst_dac_strobe", dac_strobe, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_fifo_level", fifo_level, 0);
        mq.delete();
        sb.delete();
        mode = M_IDLE; phase = 0; m_dac = '0; m_und = 0; en_prev = 0;
        en_play = 0; flush = 0; in_valid = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_fifo_level", fifo_level, 0);
    endtask

    int vals[4] = '{100, -200, 4095, -4096};

    initial begin
        #12;
        chk("init_dac_data", dac_data, 0);
        chk("init_dac_strobe", dac_strobe, 0);
        chk("init_underrun", underrun, 0);
        chk("init_fifo_level", fifo_level, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init_in_ready", in_ready, 1);

        // basic play, then run dry into underrun
        en_play = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data  = W'(vals[i]);
            step();
        end
        in_valid = 0;
        repeat (45) step();

        // stop, flush, prime with 5 and 6, play until underrun
        en_play = 0;
        step();
        flush = 1;
        step();
        flush = 0;
        in_valid = 1;
        in_data = 13'd5;
        step();
        in_data = 13'd6;
        step();
        in_valid = 0;
        en_play = 1;
        repeat (40) step();

        // backpressure while stopped, then refill while playing
        en_play = 0;
        step();
        in_valid = 1;
        repeat (6) begin
            in_data = W'($urandom);
            step();
        end
        en_play = 1;
        repeat (30) begin
            in_data = W'($urandom);
            step();
        end

        // flush colliding with a push and a slot
        run_to_phase(P - 1);
        flush = 1;
        in_data = 13'h0abc;
        step();
        flush = 0;
        in_valid = 0;
        repeat (3) step();

        // stop mid-period with data queued, then restart
        in_valid = 1;
        repeat (3) begin
            in_data = W'($urandom);
            step();
        end
        in_valid = 0;
        run_to_phase(3);
        en_play = 0;
        repeat (4) step();
        en_play = 1;
        repeat (25) step();

        // randomized traffic
        repeat (700) begin
            in_valid = $urandom_range(0, 2) != 0;
            in_data  = W'($urandom);
            flush    = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 59) == 0) en_play = ~en_play;
            step();
        end
        flush = 0;

        // asynchronous reset while running
        en_play = 1;
        in_valid = 1;
        repeat (5) begin
            in_data = W'($urandom);
            step();
        end
        in_valid = 0;
        repeat (6) step();
        async_reset();
        en_play = 1;
        in_valid = 1;
        repeat (3) begin
            in_data = W'($urandom);
            step();
        end
        in_valid = 0;
        repeat (15) step();

        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
